// File: rtl/poly_operand_sender_if.sv
// Handshake bundle between the operand sender, its host and the quadratic evaluator.
// The master side is the sender itself; the slave side is the host/evaluator pairing.
interface poly_operand_sender_if;
  logic       start;
  logic [7:0] opA;
  logic [7:0] opB;
  logic [7:0] opC;
  logic [7:0] opX;
  logic [7:0] dataResult;
  logic       go;
  logic [7:0] dataOut;
  logic       busy;
  logic       resultValid;
  logic [7:0] result;
  logic       mismatch;

  modport master (
    input  start, opA, opB, opC, opX, dataResult,
    output go, dataOut, busy, resultValid, result, mismatch
  );

  modport slave (
    output start, opA, opB, opC, opX, dataResult,
    input  go, dataOut, busy, resultValid, result, mismatch
  );
endinterface

// File: rtl/poly_operand_sender.sv
// Serial loader for the quadratic evaluator: streams A,B,C,X over Go/DataIn, then captures DataResult.
// Optional result checker is compiled in with the POLY_SENDER_CHECK_EN macro.
module poly_operand_sender #(
  parameter int GO_CYCLES   = 1,
  parameter int RESULT_WAIT = 6
) (
  input logic                   clock_i,
  input logic                   resetn_i,
  poly_operand_sender_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap,
    StWait
  } state_e;

  localparam logic [3:0] GoLast   = 4'(GO_CYCLES - 1);
  localparam logic [3:0] WaitLast = 4'(RESULT_WAIT - 1);

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [3:0]      cnt_q;
  logic [3:0][7:0] op_q;
  logic            go_q;
  logic [7:0]      dataOut_q;
  logic            busy_q;
  logic            resultValid_q;
  logic [7:0]      result_q;
  logic [7:0]      nextOperand_d;

  // Index wraps to A when idx is 3; that value is never loaded because X has no successor.
  always_comb begin
    nextOperand_d = op_q[idx_q + 2'd1];
  end

`ifdef POLY_SENDER_CHECK_EN
  logic       mismatch_q;
  logic [7:0] refValue_d;

  always_comb begin
    refValue_d = op_q[0] * op_q[3] * op_q[3] + op_q[1] * op_q[3] + op_q[2];
  end

  assign bus.mismatch = mismatch_q;
`else
  assign bus.mismatch = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= StIdle;
      idx_q         <= 2'd0;
      cnt_q         <= 4'd0;
      op_q          <= '0;
      go_q          <= 1'b0;
      dataOut_q     <= 8'd0;
      busy_q        <= 1'b0;
      resultValid_q <= 1'b0;
      result_q      <= 8'd0;
`ifdef POLY_SENDER_CHECK_EN
      mismatch_q    <= 1'b0;
`endif
    end else begin
      resultValid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q      <= {bus.opX, bus.opC, bus.opB, bus.opA};
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            dataOut_q <= bus.opA;
            go_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StDrive;
          end
        end

        // The next operand is presented during the gap so it is stable before Go rises again.
        StDrive: begin
          if (cnt_q == GoLast) begin
            cnt_q   <= 4'd0;
            go_q    <= 1'b0;
            state_q <= StGap;
            if (idx_q != 2'd3) begin
              dataOut_q <= nextOperand_d;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        StGap: begin
          if (idx_q != 2'd3) begin
            idx_q   <= idx_q + 2'd1;
            go_q    <= 1'b1;
            state_q <= StDrive;
          end else begin
            cnt_q   <= 4'd0;
            state_q <= StWait;
          end
        end

        StWait: begin
          if (cnt_q == WaitLast) begin
            cnt_q         <= 4'd0;
            result_q      <= bus.dataResult;
            resultValid_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
`ifdef POLY_SENDER_CHECK_EN
            mismatch_q    <= (bus.dataResult != refValue_d);
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        default: begin
          state_q <= StIdle;
          go_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.go          = go_q;
  assign bus.dataOut     = dataOut_q;
  assign bus.busy        = busy_q;
  assign bus.resultValid = resultValid_q;
  assign bus.result      = result_q;

endmodule

// File: tb/tb_poly_operand_sender.sv
// Directed bench for poly_operand_sender with a behavioural evaluator on each of two instances
// (GO_CYCLES=1 and GO_CYCLES=3); the evaluator publishes its result 5 cycles after the X gap.
module tb_poly_operand_sender;

`ifdef POLY_SENDER_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic            clock;
  logic            resetn;
  logic [1:0]      startV;
  logic [7:0]      opA, opB, opC, opX;
  logic            forceBad;
  logic [1:0][7:0] evalResult;
  logic [1:0]      goW, busyW, validW, mismatchW;
  logic [1:0][7:0] dataOutW, resultW;

  int checks   = 0;
  int failures = 0;

  poly_operand_sender_if busG1 ();
  poly_operand_sender_if busG3 ();

  assign busG1.start      = startV[0];
  assign busG1.opA        = opA;
  assign busG1.opB        = opB;
  assign busG1.opC        = opC;
  assign busG1.opX        = opX;
  assign busG1.dataResult = evalResult[0];
  assign busG3.start      = startV[1];
  assign busG3.opA        = opA;
  assign busG3.opB        = opB;
  assign busG3.opC        = opC;
  assign busG3.opX        = opX;
  assign busG3.dataResult = evalResult[1];

  assign goW[0]       = busG1.go;
  assign goW[1]       = busG3.go;
  assign busyW[0]     = busG1.busy;
  assign busyW[1]     = busG3.busy;
  assign validW[0]    = busG1.resultValid;
  assign validW[1]    = busG3.resultValid;
  assign mismatchW[0] = busG1.mismatch;
  assign mismatchW[1] = busG3.mismatch;
  assign dataOutW[0]  = busG1.dataOut;
  assign dataOutW[1]  = busG3.dataOut;
  assign resultW[0]   = busG1.result;
  assign resultW[1]   = busG3.result;

  poly_operand_sender #(.GO_CYCLES(1), .RESULT_WAIT(6)) dut (
    .clock_i  (clock),
    .resetn_i (resetn),
    .bus      (busG1)
  );

  poly_operand_sender #(.GO_CYCLES(3), .RESULT_WAIT(6)) dut3 (
    .clock_i  (clock),
    .resetn_i (resetn),
    .bus      (busG3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Evaluator stand-in: loads DataIn on each Go rise, result register updates 5 edges after the X gap ends.
  for (genvar g = 0; g < 2; g++) begin : gEval
    logic       goPrev;
    logic [2:0] loadCnt;
    logic [2:0] timer;
    logic [7:0] res;
    logic [7:0] slot [4];

    always @(posedge clock) begin
      if (!resetn) begin
        goPrev  <= 1'b0;
        loadCnt <= 3'd0;
        timer   <= 3'd0;
        res     <= 8'd0;
      end else begin
        goPrev <= goW[g];
        if (goW[g] && !goPrev && loadCnt < 3'd4) begin
          slot[loadCnt[1:0]] <= dataOutW[g];
          loadCnt            <= loadCnt + 3'd1;
          if (loadCnt == 3'd0) res <= 8'hEE;
        end
        if (!goW[g] && goPrev && loadCnt == 3'd4) begin
          timer   <= 3'd5;
          loadCnt <= 3'd0;
        end
        if (timer != 3'd0) begin
          if (timer == 3'd1)
            res <= forceBad ? 8'h55 : (slot[0] * slot[3] * slot[3] + slot[1] * slot[3] + slot[2]);
          timer <= timer - 3'd1;
        end
      end
    end

    assign evalResult[g] = res;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int g, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] x);
    opA       = a;
    opB       = b;
    opC       = c;
    opX       = x;
    startV[g] = 1'b1;
  endtask

  // Starts a transfer in the current cycle and checks every cycle through the ResultValid cycle.
  task automatic runTransfer(input string name, input int g, input int goCycles,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] x, input logic [7:0] expResult,
                             input int rpA, input int rpB);
    logic [7:0] ops [4];
    int period, lastCycle, k, pos;
    logic expGo;
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = x;
    period    = goCycles + 1;
    lastCycle = 4 * period + 6 + 1;
    applyStimulus(g, a, b, c, x);
    for (int n = 1; n <= lastCycle; n++) begin
      @(negedge clock);
      startV[g] = (n == rpA) || (n == rpB);
      opA = a ^ 8'h5A; opB = b ^ 8'hA5; opC = c ^ 8'h3C; opX = x ^ 8'hC3;
      k     = (n - 1) / period;
      pos   = (n - 1) % period;
      expGo = (n <= 4 * period) && (pos < goCycles);
      checkOutput({name, ".go"}, 8'(goW[g]), 8'(expGo));
      if (expGo) checkOutput({name, ".dataOut"}, dataOutW[g], ops[2'(k)]);
      if (n > 4 * period) checkOutput({name, ".dataOutHoldX"}, dataOutW[g], x);
      checkOutput({name, ".busy"}, 8'(busyW[g]), 8'(n < lastCycle));
      checkOutput({name, ".resultValid"}, 8'(validW[g]), 8'(n == lastCycle));
    end
    startV[g] = 1'b0;
    checkOutput({name, ".result"}, resultW[g], expResult);
  endtask

  task automatic idleCycles(input string name, input int g, input int count, input logic [7:0] expResult);
    repeat (count) begin
      @(negedge clock);
      checkOutput({name, ".idleValid"}, 8'(validW[g]), 8'd0);
      checkOutput({name, ".idleBusy"}, 8'(busyW[g]), 8'd0);
      checkOutput({name, ".idleGo"}, 8'(goW[g]), 8'd0);
      checkOutput({name, ".resultHeld"}, resultW[g], expResult);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    startV   = 2'b00;
    forceBad = 1'b0;
    opA = 8'd0; opB = 8'd0; opC = 8'd0; opX = 8'd0;
    repeat (2) @(negedge clock);
    checkOutput("reset.go", 8'(goW[0]), 8'd0);
    checkOutput("reset.dataOut", dataOutW[0], 8'd0);
    checkOutput("reset.busy", 8'(busyW[0]), 8'd0);
    checkOutput("reset.resultValid", 8'(validW[0]), 8'd0);
    checkOutput("reset.result", resultW[0], 8'd0);
    checkOutput("reset.mismatch", 8'(mismatchW[0]), 8'd0);
    checkOutput("reset.go3", 8'(goW[1]), 8'd0);
    checkOutput("reset.busy3", 8'(busyW[1]), 8'd0);
    resetn = 1'b1;

    runTransfer("t1", 0, 1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd27, 0, 0);
    idleCycles("t1", 0, 2, 8'd27);

    runTransfer("t2", 0, 1, 8'd3, 8'd5, 8'd7, 8'd10, 8'd101, 0, 0);
    checkOutput("t2.mismatch", 8'(mismatchW[0]), 8'd0);
    idleCycles("t2", 0, 1, 8'd101);

    runTransfer("t3", 1, 3, 8'd2, 8'd0, 8'd1, 8'd3, 8'd19, 0, 0);
    idleCycles("t3", 1, 1, 8'd19);

    runTransfer("t4", 0, 1, 8'd5, 8'd6, 8'd7, 8'd8, 8'd119, 5, 14);
    runTransfer("t4b", 0, 1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd69, 0, 0);
    idleCycles("t4b", 0, 1, 8'd69);

    applyStimulus(0, 8'd8, 8'd9, 8'd10, 8'd11);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clock);
      startV[0] = 1'b0;
    end
    checkOutput("t5.goInC", 8'(goW[0]), 8'd1);
    checkOutput("t5.dataOutC", dataOutW[0], 8'd10);
    resetn = 1'b0;
    #1;
    checkOutput("t5.rstGo", 8'(goW[0]), 8'd0);
    checkOutput("t5.rstBusy", 8'(busyW[0]), 8'd0);
    checkOutput("t5.rstDataOut", dataOutW[0], 8'd0);
    checkOutput("t5.rstResult", resultW[0], 8'd0);
    checkOutput("t5.rstValid", 8'(validW[0]), 8'd0);
    @(negedge clock);
    resetn = 1'b1;
    runTransfer("t5b", 0, 1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd3, 0, 0);
    idleCycles("t5b", 0, 1, 8'd3);

    forceBad = 1'b1;
    runTransfer("t6", 0, 1, 8'd1, 8'd2, 8'd3, 8'd4, 8'h55, 0, 0);
    forceBad = 1'b0;
    checkOutput("t6.mismatchSet", 8'(mismatchW[0]), 8'(CheckEn));
    idleCycles("t6", 0, 1, 8'h55);
    checkOutput("t6.mismatchHeld", 8'(mismatchW[0]), 8'(CheckEn));
    runTransfer("t6b", 0, 1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd27, 0, 0);
    checkOutput("t6b.mismatchClr", 8'(mismatchW[0]), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
